// File: rtl/rcc_reg2ahb_master.sv
// Register-request to AHB-Lite master bridge: each accepted access becomes one
// NONSEQ SINGLE transfer, completed with a one-cycle response pulse.
module rcc_reg2ahb_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int WW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [WW-1:0] we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          rsp_valid,
    output logic [1:0]    rsp,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [3:0]    hprot,
    output logic [DW-1:0] hwdata,
    input  logic          hready,
    input  logic          hresp,
    input  logic [DW-1:0] hrdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RSP_OKAY      = 2'b00;
    localparam logic [1:0] RSP_ERROR     = 2'b01;
    localparam logic [1:0] RSP_STRB      = 2'b10;

    state_t        state_q, state_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_q, rsp_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          dec_legal;
    logic [2:0]    dec_size;
    logic [1:0]    dec_off;

    // Returns {legal, hsize, haddr[1:0]} for a strobe pattern.
    function automatic logic [5:0] decode_strb(input logic [3:0] strb);
        logic [5:0] r;
        case (strb)
            4'b0000: r = {1'b1, 3'b010, 2'b00};
            4'b1111: r = {1'b1, 3'b010, 2'b00};
            4'b0011: r = {1'b1, 3'b001, 2'b00};
            4'b1100: r = {1'b1, 3'b001, 2'b10};
            4'b0001: r = {1'b1, 3'b000, 2'b00};
            4'b0010: r = {1'b1, 3'b000, 2'b01};
            4'b0100: r = {1'b1, 3'b000, 2'b10};
            4'b1000: r = {1'b1, 3'b000, 2'b11};
            default: r = {1'b0, 3'b000, 2'b00};
        endcase
        return r;
    endfunction

    assign {dec_legal, dec_size, dec_off} = decode_strb(we);

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (dec_legal) begin
                        haddr_d  = {addr[AW-1:2], dec_off};
                        hwrite_d = |we;
                        hsize_d  = dec_size;
                        htrans_d = HTRANS_NONSEQ;
                        wdata_d  = wdata;
                        state_d  = ADDR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_d       = RSP_STRB;
                        rdata_d     = '0;
                    end
                end
            end
            ADDR: begin
                if (hready) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_d       = hresp ? RSP_ERROR : RSP_OKAY;
                    rdata_d     = (hresp || hwrite_q) ? '0 : hrdata;
                    state_d     = IDLE;
                end else if (hresp) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                // Second cycle of the two-cycle AHB error response.
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_d       = RSP_ERROR;
                    rdata_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= RSP_OKAY;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp       = rsp_q;
    assign rdata     = rdata_q;
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hwdata    = hwdata_q;

endmodule

// File: doc/rcc_reg2ahb_master.md
Name: rcc_reg2ahb_master

Overview:
- Register-request to AHB-Lite master bridge. It is the initiator-side counterpart of the AHB-to-register slave bridge used on the RCC bus.
- Accepts single register accesses (req/we/addr/wdata) from an RCC-internal requester, e.g. a boot/option-byte loader or a debug sequencer.
- Issues each access as one AHB-Lite NONSEQ SINGLE transfer and returns read data plus a response code.
- Sits between that requester and the system AHB-Lite fabric.

Parameters:
- AW, 32, address width (haddr, addr).
- DW, 32, data width (hwdata, hrdata, wdata, rdata); only 32 is supported.
- WW, 4, write-strobe width, DW/8.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous active-high reset.
- req  input  1  access request; sampled only while ready=1.
- we  input  WW  byte write strobes; all zeros = read.
- addr  input  AW  byte address.
- wdata  input  DW  write data.
- ready  output  1  bridge idle; a transfer is accepted when req=1 and ready=1.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp  output  2  response: 00 OKAY, 01 AHB ERROR, 10 illegal strobe; valid with rsp_valid.
- rdata  output  DW  read data; valid with rsp_valid for reads, else 0.
- haddr  output  AW  AHB address.
- htrans  output  2  AHB transfer type: 00 IDLE, 10 NONSEQ.
- hwrite  output  1  AHB write.
- hsize  output  3  AHB size.
- hburst  output  3  constant 000 (SINGLE).
- hprot  output  4  constant 0011.
- hwdata  output  DW  AHB write data.
- hready  input  1  AHB transfer ready.
- hresp  input  1  AHB response: 0 OKAY, 1 ERROR.
- hrdata  input  DW  AHB read data.

Behaviour:
- Reset values: haddr=0, htrans=00, hwrite=0, hsize=000, hwdata=0, rsp_valid=0, rsp=00, rdata=0, state=IDLE. ready is decoded from state, so it is 1 during reset.
- Reset mid-transfer forces IDLE immediately. No completion pulse is issued for the aborted access.
- Strobe decode:
  - 1111 -> hsize=010, haddr[1:0]=00.
  - 0011 -> hsize=001, haddr[1:0]=00.
  - 1100 -> hsize=001, haddr[1:0]=10.
  - One-hot bit n -> hsize=000, haddr[1:0]=n.
  - Read (0000) -> hsize=010, haddr[1:0]=00.
  - addr[AW-1:2] passes through unchanged.
  - Any other pattern is illegal.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE, ready=1:
  - req=1 with legal strobes: register haddr/hwrite/hsize, set htrans=10, latch wdata, go to ADDR.
  - req=1 with illegal strobes: no bus activity; next cycle rsp_valid=1, rsp=10; stay IDLE.
- ADDR, ready=0, htrans=10:
  - hold all address-phase signals while hready=0.
  - On a clock edge with hready=1: htrans<=00, hwdata<=latched wdata (writes only, else 0), go to DATA.
- DATA, htrans=00:
  - hready=1, hresp=0: capture hrdata into rdata (reads only), rsp_valid=1, rsp=00 next cycle; go to IDLE.
  - hready=0, hresp=1 (first ERROR cycle): go to ERR.
  - hready=1, hresp=1 (malformed single-cycle error): complete with rsp=01; go to IDLE.
  - hready=0, hresp=0: wait; there is no timeout.
- ERR: on hready=1, rsp_valid=1, rsp=01, rdata=0 next cycle; go to IDLE.
- rsp_valid is high exactly one cycle. ready is 1 in the same cycle, so back-to-back accesses are allowed.
- Minimum latency (zero wait states), accept edge to rsp_valid high: 3 cycles (ADDR, DATA, response register).
- Address and data phases never overlap; at most one outstanding transfer. hwdata holds until the next transfer's data phase.
- req while ready=0 is ignored; the requester must hold req.

Test Plan:
- Read, zero-wait: req, we=0000, addr=0x4000_0010, hrdata=0xDEADBEEF -> htrans=10 for one cycle, haddr=0x4000_0010, hsize=010, hwrite=0; rsp_valid 3 cycles after accept, rsp=00, rdata=0xDEADBEEF.
- Byte write: we=0100, addr=0x4000_0021, wdata=0x00AB0000 -> haddr=0x4000_0022, hsize=000, hwrite=1; hwdata=0x00AB0000 in data phase; rsp=00.
- Wait states: hready low 2 cycles in address phase, then 3 in data phase -> htrans held 10 for 3 cycles; rsp_valid 8 cycles after accept; single pulse.
- Two-cycle ERROR: hresp=1/hready=0, then hresp=1/hready=1 -> ERR entered; rsp_valid with rsp=01, rdata=0; back to IDLE.
- Illegal strobe: we=0101 -> no htrans activity; rsp_valid next cycle with rsp=10; immediately followed by a legal req, which is accepted that cycle.
- Reset mid data phase: assert rst with hready=0 -> htrans=00, ready=1, no rsp_valid; a new read after release completes normally.
